pong_game_engine: RTL

Game-logic core of the Pong design: consumes debounced paddle commands from the keypad controller plus a frame-rate step pulse, and produces registered ball and paddle coordinates for the graphics generator and per-player scores for the score display. It contains the serve/play/point/game-over state machine, paddle motion with wall clamping, ball motion with wall and paddle reflection, and miss detection. All state advances only on `tick`, so game speed is set by the upstream tick divider, independent of `clk`.

---
 rtl/pong_game_engine.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/pong_game_engine.sv
// Pong game core: serve/play/point FSM, paddle clamping, ball reflection, scoring.
// Optional macro PONG_SPEEDUP_EN: each paddle return raises ball speed, capped at 2x.
module pong_game_engine #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 10,
  parameter int PADDLE_W    = 10,
  parameter int PADDLE_H    = 80,
  parameter int PADDLE1_X   = 20,
  parameter int PADDLE2_X   = 610,
  parameter int PADDLE_STEP = 4,
  parameter int BALL_SPEED  = 2,
  parameter int SERVE_TICKS = 60,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       up1,
  input  logic       down1,
  input  logic       up2,
  input  logic       down2,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle1_y,
  output logic [9:0] paddle2_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       point_p,
  output logic       game_over
);

  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, GAMEOVER} state_t;

  localparam int CW = $clog2(SERVE_TICKS + 1);
  localparam logic [10:0] BX0  = 11'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [10:0] BY0  = 11'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [10:0] PY0  = 11'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [10:0] PMAX = 11'(SCREEN_H - PADDLE_H);
  localparam logic [10:0] YMAX = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] XMAX = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] F1   = 11'(PADDLE1_X + PADDLE_W);
  localparam logic [10:0] F2   = 11'(PADDLE2_X - BALL_SIZE);
  localparam logic [10:0] STEP = 11'(PADDLE_STEP);
  localparam logic [10:0] BSZ  = 11'(BALL_SIZE);
  localparam logic [10:0] PH   = 11'(PADDLE_H);
  localparam logic [10:0] BASE = 11'(BALL_SPEED);
  localparam logic [CW-1:0] SLAST = CW'(SERVE_TICKS - 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  state_t state, state_n;
  logic start_q, go;
  logic dx, dy, ndx, ndy;
  logic p1_won, win;
  logic [CW-1:0] cnt;
  logic [10:0] spd, bx, by, y1, y2;
  logic [9:0] nx, ny;
  logic miss1, miss2, ov1, ov2;
  logic [3:0] sc_new;

  assign go = start & ~start_q;
  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign y1 = {1'b0, paddle1_y};
  assign y2 = {1'b0, paddle2_y};

  function automatic logic [9:0] pmove(input logic [9:0] y,
                                       input logic u,
                                       input logic d);
    logic [10:0] t;
    t = {1'b0, y};
    pmove = y;
    unique case (1'b1)
      (u & ~d): pmove = (t <= STEP) ? 10'd0 : 10'(t - STEP);
      (d & ~u): pmove = (t + STEP >= PMAX) ? PMAX[9:0] : 10'(t + STEP);
      default: pmove = y;
    endcase
  endfunction

`ifdef PONG_SPEEDUP_EN
  localparam logic [10:0] SMAX = 11'(2 * BALL_SPEED);
  // speed: base on every serve, bumped when a paddle flips dx
  always_ff @(posedge clk) begin
    if (!rst)
      spd <= BASE;
    else if (state_n == SERVE && state != SERVE)
      spd <= BASE;
    else if (state == PLAY && tick && ndx != dx && spd < SMAX)
      spd <= spd + 11'd1;
  end
`else
  assign spd = BASE;
`endif

  // one PLAY step: wall/paddle reflection and miss detection
  always_comb begin
    ov1 = (by + BSZ > y1) && (by < y1 + PH);
    ov2 = (by + BSZ > y2) && (by < y2 + PH);
    ndx = dx;
    ndy = dy;
    nx = ball_x;
    ny = ball_y;
    miss1 = 1'b0;
    miss2 = 1'b0;
    if (dy) begin
      if (by + spd >= YMAX) begin
        ny = YMAX[9:0];
        ndy = 1'b0;
      end else ny = 10'(by + spd);
    end else if (by <= spd) begin
      ny = 10'd0;
      ndy = 1'b1;
    end else ny = 10'(by - spd);
    if (!dx) begin
      if (bx <= F1 + spd && bx >= F1 && ov1) begin
        nx = F1[9:0];
        ndx = 1'b1;
      end else if (bx <= spd) begin
        nx = 10'd0;
        miss2 = 1'b1;
      end else nx = 10'(bx - spd);
    end else begin
      if (bx + spd >= F2 && bx <= F2 && ov2) begin
        nx = F2[9:0];
        ndx = 1'b0;
      end else if (bx + spd >= XMAX) begin
        nx = XMAX[9:0];
        miss1 = 1'b1;
      end else nx = 10'(bx + spd);
    end
  end

  // next-state logic
  always_comb begin
    state_n = state;
    sc_new = p1_won ? score1 + 4'd1 : score2 + 4'd1;
    win = (sc_new == WIN);
    unique case (state)
      IDLE:     if (go) state_n = SERVE;
      SERVE:    if (tick && cnt == SLAST) state_n = PLAY;
      PLAY:     if (tick && (miss1 || miss2)) state_n = POINT;
      POINT:    state_n = win ? GAMEOVER : SERVE;
      GAMEOVER: if (go) state_n = SERVE;
      default:  state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end

  // positions, directions, scores and flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      start_q <= 1'b0;
      ball_x <= BX0[9:0];
      ball_y <= BY0[9:0];
      paddle1_y <= PY0[9:0];
      paddle2_y <= PY0[9:0];
      score1 <= 4'd0;
      score2 <= 4'd0;
      point_p <= 1'b0;
      game_over <= 1'b0;
      dx <= 1'b1;
      dy <= 1'b1;
      cnt <= '0;
      p1_won <= 1'b0;
    end else begin
      start_q <= start;
      point_p <= 1'b0;
      game_over <= (state_n == GAMEOVER);
      unique case (state)
        IDLE: if (go) begin
          cnt <= '0;
          dx <= 1'b1;
          dy <= 1'b1;
        end
        SERVE: if (tick) begin
          cnt <= cnt + CW'(1);
          paddle1_y <= pmove(paddle1_y, up1, down1);
          paddle2_y <= pmove(paddle2_y, up2, down2);
        end
        PLAY: if (tick) begin
          paddle1_y <= pmove(paddle1_y, up1, down1);
          paddle2_y <= pmove(paddle2_y, up2, down2);
          ball_x <= nx;
          ball_y <= ny;
          dx <= ndx;
          dy <= ndy;
          if (miss1 || miss2) p1_won <= miss1;
        end
        POINT: begin
          point_p <= 1'b1;
          if (p1_won) score1 <= sc_new;
          else score2 <= sc_new;
          if (!win) begin
            ball_x <= BX0[9:0];
            ball_y <= BY0[9:0];
            cnt <= '0;
            dx <= p1_won;
          end
        end
        GAMEOVER: if (go) begin
          score1 <= 4'd0;
          score2 <= 4'd0;
          ball_x <= BX0[9:0];
          ball_y <= BY0[9:0];
          cnt <= '0;
          dx <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
